// File: rtl/ysyx_2022040010_mem_if.sv
// Data-memory read response bus seen by the MEM stage: one-cycle rvalid pulse with an aligned doubleword.
interface ysyx_2022040010_mem_if;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    modport master (output dmem_rvalid, output dmem_rdata);
    modport slave  (input  dmem_rvalid, input  dmem_rdata);
endinterface

// File: rtl/ysyx_2022040010_mem.sv
// MEM stage: loads wait in WAIT (stallreq high) until rvalid, then extract/extend; other ops pass with zero latency.
// A WB stall at load completion parks the data in HOLD; YSYX_MEM_MISALIGN_CHECK_EN enables the misalignment trap flag.
module ysyx_2022040010_mem (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 stall,
    input  logic [144:0]               ex_to_mem_bus,
    ysyx_2022040010_mem_if.slave       dmem,
    output logic                       stallreq_for_mem,
    output logic [133:0]               mem_to_wb_bus,
    output logic [69:0]                mem_to_rf_bus,
    output logic                       misalign_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

    state_e        state_q, state_d;
    logic [144:0]  ex_to_mem_bus_r;
    logic [63:0]   load_buf_q, load_buf_d;
    logic          buf_vld_q, buf_vld_d;

    logic [63:0]   pc, ex_result, ld_src, load_data, rf_wdata;
    logic [10:0]   mem_op;
    logic          rf_we_r, rf_we, is_load, load_go, misalign, reg_upd, use_buf;
    logic [4:0]    rf_waddr;
    logic [2:0]    off;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_word;
    logic          unused_sig;

    assign pc        = ex_to_mem_bus_r[144:81];
    assign mem_op    = ex_to_mem_bus_r[80:70];
    assign rf_we_r   = ex_to_mem_bus_r[69];
    assign rf_waddr  = ex_to_mem_bus_r[68:64];
    assign ex_result = ex_to_mem_bus_r[63:0];
    assign off       = ex_result[2:0];
    assign is_load   = |mem_op[10:4];

`ifdef YSYX_MEM_MISALIGN_CHECK_EN
    assign misalign = (|mem_op) &
                      (((mem_op[8] | mem_op[7] | mem_op[2]) & off[0]) |
                       ((mem_op[6] | mem_op[5] | mem_op[1]) & (off[1:0] != 2'b00)) |
                       ((mem_op[4] | mem_op[0]) & (off != 3'b000)));
`else
    assign misalign = 1'b0;
`endif

    assign load_go    = is_load & ~misalign;
    assign misalign_o = misalign;
    assign unused_sig = ^{stall[5], stall[2:0], mem_op[3:0]};

    // The input register is frozen while a load is outstanding so a bubble cannot destroy it.
    assign reg_upd = ~stallreq_for_mem & (~stall[3] | ~stall[4]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
        end else if (~stallreq_for_mem) begin
            if (stall[3] && !stall[4]) ex_to_mem_bus_r <= '0;
            else if (!stall[3])        ex_to_mem_bus_r <= ex_to_mem_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            load_buf_q <= '0;
            buf_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_buf_q <= load_buf_d;
            buf_vld_q  <= buf_vld_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        stallreq_for_mem = 1'b0;
        load_buf_d       = load_buf_q;
        buf_vld_d        = buf_vld_q;
        unique case (state_q)
            S_IDLE: begin
                // buf_vld_q marks a load already served by WAIT; do not request it again.
                if (load_go && !buf_vld_q && !dmem.dmem_rvalid) begin
                    state_d          = S_WAIT;
                    stallreq_for_mem = 1'b1;
                end
            end
            S_WAIT: begin
                stallreq_for_mem = 1'b1;
                if (dmem.dmem_rvalid) state_d = stall[4] ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!stall[4]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q == S_WAIT && dmem.dmem_rvalid) begin
            load_buf_d = dmem.dmem_rdata;
            buf_vld_d  = 1'b1;
        end else if (reg_upd) begin
            buf_vld_d  = 1'b0;
        end
    end

    assign use_buf = (state_q == S_HOLD) | buf_vld_q;
    assign ld_src  = use_buf ? load_buf_q : dmem.dmem_rdata;
    assign ld_byte = ld_src[{off, 3'b000} +: 8];
    assign ld_half = ld_src[{off[2:1], 4'b0000} +: 16];
    assign ld_word = ld_src[{off[2], 5'b00000} +: 32];

    always_comb begin
        load_data = ld_src;
        if (mem_op[10])     load_data = {{56{ld_byte[7]}}, ld_byte};
        else if (mem_op[9]) load_data = {56'b0, ld_byte};
        else if (mem_op[8]) load_data = {{48{ld_half[15]}}, ld_half};
        else if (mem_op[7]) load_data = {48'b0, ld_half};
        else if (mem_op[6]) load_data = {{32{ld_word[31]}}, ld_word};
        else if (mem_op[5]) load_data = {32'b0, ld_word};
    end

    assign rf_wdata = is_load ? load_data : ex_result;
    assign rf_we    = rf_we_r & (rf_waddr != 5'd0) & ~stallreq_for_mem & ~(is_load & misalign);

    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
endmodule

// File: tb/tb_ysyx_2022040010_mem.sv
// Directed and randomized scenarios for the MEM stage, checked against a behavioural load model.
module tb_ysyx_2022040010_mem;
    localparam logic [10:0] OP_LB  = 11'h400, OP_LBU = 11'h200, OP_LH  = 11'h100, OP_LHU = 11'h080;
    localparam logic [10:0] OP_LW  = 11'h040, OP_LWU = 11'h020, OP_LD  = 11'h010, OP_SB  = 11'h008;
    localparam logic [10:0] OP_SH  = 11'h004, OP_SW  = 11'h002, OP_SD  = 11'h001;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic [144:0]  ex_bus;
    logic          stallreq;
    logic [133:0]  wb_bus;
    logic [69:0]   rf_bus;
    logic          misalign;
    logic [205:0]  obs;
    int            checks = 0;
    int            errors = 0;

    ysyx_2022040010_mem_if dmem_bus ();

    ysyx_2022040010_mem dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (ex_bus),
        .dmem             (dmem_bus),
        .stallreq_for_mem (stallreq),
        .mem_to_wb_bus    (wb_bus),
        .mem_to_rf_bus    (rf_bus),
        .misalign_o       (misalign)
    );

    always #5 clk = ~clk;
    assign obs = {stallreq, misalign, wb_bus, rf_bus};

    function automatic logic [144:0] mk(input logic [63:0] pc, input logic [10:0] op,
                                        input logic we, input logic [4:0] wa, input logic [63:0] res);
        return {pc, op, we, wa, res};
    endfunction

    function automatic logic [205:0] ev(input logic sr, input logic mis, input logic [63:0] pc,
                                        input logic we, input logic [4:0] wa, input logic [63:0] wd);
        return {sr, mis, pc, we, wa, wd, we, wa, wd};
    endfunction

    // Reference load result: shift the doubleword down to the addressed lane, then sign-extend arithmetically.
    function automatic logic [63:0] load_val(input logic [10:0] op, input logic [63:0] addr, input logic [63:0] rd);
        int unsigned o;
        logic [63:0] b, h, w;
        o = 32'(addr[2:0]);
        b = (rd >> (o * 8)) & 64'hFF;
        h = (rd >> ((o / 2) * 16)) & 64'hFFFF;
        w = (rd >> ((o / 4) * 32)) & 64'hFFFF_FFFF;
        case (op)
            OP_LB:   return (b ^ 64'h80) - 64'h80;
            OP_LBU:  return b;
            OP_LH:   return (h ^ 64'h8000) - 64'h8000;
            OP_LHU:  return h;
            OP_LW:   return (w ^ 64'h8000_0000) - 64'h8000_0000;
            OP_LWU:  return w;
            OP_LD:   return rd;
            default: return 64'h0;
        endcase
    endfunction

    function automatic int size_of(input logic [10:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_LWU, OP_SW: return 4;
            OP_LD, OP_SD:         return 8;
            default:              return 1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'b111111;
        ex_bus = {17'($urandom), $urandom, $urandom, $urandom, $urandom};
        dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = {$urandom, $urandom};
        step();
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 0)); end
        step();
        rst = 1'b0; stall = '0; ex_bus = '0; dmem_bus.dmem_rvalid = 1'b0;
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_after: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 0)); end
        step();
    endtask

    task automatic test_lb_wait();
        ex_bus = mk(64'h1000, OP_LB, 1'b1, 5'd5, 64'h8000_0003); stall = '0;
        step();
        ex_bus = '0; stall = 6'b001111;
        for (int c = 0; c < 2; c++) begin
            dmem_bus.dmem_rvalid = (c == 1);
            dmem_bus.dmem_rdata  = 64'h0000_0000_80FF_0000;
            @(negedge clk); checks++;
            if ({stallreq, wb_bus[69], rf_bus[69]} !== 3'b100) begin errors++; $display("FAIL lb_wait_req: got %b expected 100", {stallreq, wb_bus[69], rf_bus[69]}); end
            step();
        end
        dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = {$urandom, $urandom}; stall = '0;
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 64'h1000, 1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80)) begin
            errors++; $display("FAIL lb_wait_data: got %h expected %h", obs, ev(0, 0, 64'h1000, 1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80));
        end
        step();
    endtask

    task automatic test_lwu_direct();
        ex_bus = mk(64'h2000, OP_LWU, 1'b1, 5'd7, 64'h2004);
        step();
        ex_bus = '0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 64'h8000_0001_0000_0000;
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 64'h2000, 1, 5'd7, 64'h0000_0000_8000_0001)) begin
            errors++; $display("FAIL lwu_direct: got %h expected %h", obs, ev(0, 0, 64'h2000, 1, 5'd7, 64'h0000_0000_8000_0001));
        end
        step();
        dmem_bus.dmem_rvalid = 1'b0;
    endtask

    task automatic test_ld_hold();
        logic [63:0] r1, r2;
        r1 = 64'hDEAD_BEEF_0123_4567; r2 = {$urandom, $urandom};
        ex_bus = mk(64'h3000, OP_LD, 1'b1, 5'd9, 64'h3008); stall = '0;
        step();
        ex_bus = '0;
        for (int c = 0; c < 2; c++) begin
            stall = (c == 0) ? 6'b001111 : 6'b011111;
            dmem_bus.dmem_rvalid = (c == 1); dmem_bus.dmem_rdata = r1;
            @(negedge clk); checks++;
            if ({stallreq, wb_bus[69], rf_bus[69]} !== 3'b100) begin errors++; $display("FAIL ld_hold_req: got %b expected 100", {stallreq, wb_bus[69], rf_bus[69]}); end
            step();
        end
        dmem_bus.dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall  = (i < 2) ? 6'b011111 : 6'b000000;
            ex_bus = (i == 2) ? mk(64'h3100, OP_LBU, 1'b1, 5'd3, 64'h3105) : '0;
            dmem_bus.dmem_rdata = {$urandom, $urandom};
            @(negedge clk); checks++;
            if (obs !== ev(0, 0, 64'h3000, 1, 5'd9, r1)) begin errors++; $display("FAIL ld_hold_stable: got %h expected %h", obs, ev(0, 0, 64'h3000, 1, 5'd9, r1)); end
            step();
        end
        ex_bus = '0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = r2;
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 64'h3100, 1, 5'd3, load_val(OP_LBU, 64'h3105, r2))) begin
            errors++; $display("FAIL ld_hold_idle: got %h expected %h", obs, ev(0, 0, 64'h3100, 1, 5'd3, load_val(OP_LBU, 64'h3105, r2)));
        end
        step();
        dmem_bus.dmem_rvalid = 1'b0;
    endtask

    task automatic test_bubble();
        ex_bus = mk(64'h4000, 11'h0, 1'b1, 5'd4, 64'h1234_5678_9ABC_DEF0);
        step();
        ex_bus = mk(64'h4100, 11'h0, 1'b1, 5'd4, 64'h5555); stall = 6'b001000;
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 64'h4000, 1, 5'd4, 64'h1234_5678_9ABC_DEF0)) begin
            errors++; $display("FAIL bubble_pre: got %h expected %h", obs, ev(0, 0, 64'h4000, 1, 5'd4, 64'h1234_5678_9ABC_DEF0));
        end
        step();
        stall = '0; ex_bus = '0;
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL bubble: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 0)); end
        step();
    endtask

    task automatic test_waddr_zero();
        ex_bus = mk(64'h7000, 11'h0, 1'b1, 5'd0, 64'hCAFE);
        step();
        ex_bus = '0;
        @(negedge clk); checks++;
        if (obs !== ev(0, 0, 64'h7000, 0, 5'd0, 64'hCAFE)) begin errors++; $display("FAIL waddr_zero: got %h expected %h", obs, ev(0, 0, 64'h7000, 0, 5'd0, 64'hCAFE)); end
        step();
    endtask

    task automatic test_reset_in_wait();
        ex_bus = mk(64'h5000, OP_LW, 1'b1, 5'd6, 64'h5000);
        step();
        ex_bus = '0; stall = 6'b001111;
        for (int c = 0; c < 2; c++) begin
            rst = (c == 1);
            @(negedge clk); checks++;
            if ({stallreq, wb_bus[69], rf_bus[69]} !== 3'b100) begin errors++; $display("FAIL rstwait_req: got %b expected 100", {stallreq, wb_bus[69], rf_bus[69]}); end
            step();
        end
        rst = 1'b0; stall = '0;
        for (int c = 0; c < 2; c++) begin
            dmem_bus.dmem_rvalid = (c == 0); dmem_bus.dmem_rdata = {$urandom, $urandom};
            @(negedge clk); checks++;
            if (obs !== ev(0, 0, 0, 0, 0, 0)) begin errors++; $display("FAIL rstwait_idle: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 0)); end
            step();
        end
    endtask

    task automatic test_misalign();
        logic [63:0] r;
        r = 64'hAAAA_BBBB_CCCC_8001;
        ex_bus = mk(64'h6000, OP_LH, 1'b1, 5'd8, 64'h6001);
        step();
        ex_bus = '0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = r;
        @(negedge clk); checks++;
`ifdef YSYX_MEM_MISALIGN_CHECK_EN
        if ({misalign, stallreq, wb_bus[69], rf_bus[69]} !== 4'b1000) begin
            errors++; $display("FAIL misalign_lh: got %b expected 1000", {misalign, stallreq, wb_bus[69], rf_bus[69]});
        end
`else
        if (obs !== ev(0, 0, 64'h6000, 1, 5'd8, 64'hFFFF_FFFF_FFFF_8001)) begin
            errors++; $display("FAIL misalign_lh: got %h expected %h", obs, ev(0, 0, 64'h6000, 1, 5'd8, 64'hFFFF_FFFF_FFFF_8001));
        end
`endif
        step();
        dmem_bus.dmem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [10:0] ops [11];
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD, OP_SB, OP_SH, OP_SW, OP_SD};
        for (int n = 0; n < 80; n++) begin
            logic [10:0] op;
            logic [63:0] pc, res, rd, exp_wd;
            logic [4:0]  wa;
            logic        we, exp_we, ld;
            int          k, lat, hold;
            k = $urandom_range(0, 14);
            op = (k <= 10) ? ops[k] : 11'h0;
            pc = {$urandom, $urandom}; res = {$urandom, $urandom}; rd = {$urandom, $urandom};
            wa = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
            lat = $urandom_range(0, 3); hold = $urandom_range(0, 2);
            if (op != 11'h0) res = res & ~(64'(size_of(op)) - 64'd1);
            ld = (op & 11'h7F0) != 11'h0;
            exp_we = we && (wa != 5'd0);
            exp_wd = ld ? load_val(op, res, rd) : res;
            ex_bus = mk(pc, op, we, wa, res); stall = '0; dmem_bus.dmem_rvalid = 1'b0;
            step();
            ex_bus = '0;
            if (ld && lat > 0) begin
                for (int c = 0; c <= lat; c++) begin
                    stall = 6'b001111 | (((c == lat) && (hold > 0)) ? 6'b010000 : 6'b000000);
                    dmem_bus.dmem_rvalid = (c == lat);
                    dmem_bus.dmem_rdata  = (c == lat) ? rd : {$urandom, $urandom};
                    @(negedge clk); checks++;
                    if ({stallreq, wb_bus[69], rf_bus[69]} !== 3'b100) begin
                        errors++; $display("FAIL rand_wait[%0d]: got %b expected 100", n, {stallreq, wb_bus[69], rf_bus[69]});
                    end
                    step();
                end
                dmem_bus.dmem_rvalid = 1'b0;
                for (int h = 1; h <= ((hold > 0) ? hold : 1); h++) begin
                    stall = (h < hold) ? 6'b011111 : 6'b000000;
                    dmem_bus.dmem_rdata = {$urandom, $urandom};
                    @(negedge clk); checks++;
                    if (obs !== ev(0, 0, pc, exp_we, wa, exp_wd)) begin
                        errors++; $display("FAIL rand_load_late[%0d]: got %h expected %h", n, obs, ev(0, 0, pc, exp_we, wa, exp_wd));
                    end
                    step();
                end
            end else begin
                dmem_bus.dmem_rvalid = ld ? 1'b1 : 1'($urandom_range(0, 1));
                dmem_bus.dmem_rdata  = ld ? rd : {$urandom, $urandom};
                @(negedge clk); checks++;
                if (obs !== ev(0, 0, pc, exp_we, wa, exp_wd)) begin
                    errors++; $display("FAIL rand_direct[%0d]: got %h expected %h", n, obs, ev(0, 0, pc, exp_we, wa, exp_wd));
                end
                step();
                dmem_bus.dmem_rvalid = 1'b0;
            end
            stall = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = '0; ex_bus = '0;
        dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
        #1;
        test_reset();
        test_lb_wait();
        test_lwu_direct();
        test_ld_hold();
        test_bubble();
        test_waddr_zero();
        test_reset_in_wait();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
